uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a small transmit FIFO.
// Sends 8N1 frames (start bit, 8 data bits LSB first, stop bit), each bit
// held for CLKS_PER_BIT clocks. full, busy and tx all come straight from flops.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       we,
   output logic       full,
   output logic       busy,
   output logic       tx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] baud_cnt, baud_next;
   logic [2:0]       bit_idx, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic             tx_next;

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count, count_next;
   logic             push, pop, baud_done;

   // A write is only taken when there is room; a full FIFO drops the byte even
   // if the transmitter frees a slot on the same edge.
   assign push      = we && (count != DEPTH_CNT);
   assign pop       = (state == IDLE) && (count != '0);
   assign baud_done = (baud_cnt == BAUD_LAST);

   // Occupancy bookkeeping: simultaneous push and pop cancel out.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + COUNT_ONE;
         2'b01:   count_next = count - COUNT_ONE;
         default: count_next = count;
      endcase
   end

   // FIFO pointers and count; pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_next;
      end
   end

   // FIFO storage needs no reset; the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (!rst && push) fifo_mem[wr_ptr] <= din;
   end

   // Frame sequencer: decides the next state, baud count, bit index and shifter.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_idx;
      shift_next = shift_reg;
      case (state)
         IDLE: begin
            if (pop) begin
               state_next = START;
               baud_next  = '0;
               bit_next   = '0;
               shift_next = fifo_mem[rd_ptr];
            end
         end
         START: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = DATA;
            end else begin
               baud_next = baud_cnt + BAUD_ONE;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_next  = '0;
               shift_next = {1'b0, shift_reg[7:1]};
               bit_next   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = STOP;
            end else begin
               baud_next = baud_cnt + BAUD_ONE;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_next  = '0;
               state_next = IDLE;
            end else begin
               baud_next = baud_cnt + BAUD_ONE;
            end
         end
         default: state_next = IDLE;
      endcase

      // The line level is decoded from the upcoming state so tx is a plain flop.
      tx_next = 1'b1;
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   // Sequencer state and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         full      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_next;
         bit_idx   <= bit_next;
         shift_reg <= shift_next;
         tx        <= tx_next;
         full      <= (count_next == DEPTH_CNT);
         busy      <= (count_next != '0) || (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at 4 clocks per bit and a 4-entry FIFO.
module tb_uart_tx;

   localparam int CLKS  = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       we  = 1'b0;
   logic [7:0] din = 8'h00;
   logic       full, busy, tx;

   int checks = 0;
   int errors = 0;

   uart_tx #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .din(din), .we(we),
      .full(full), .busy(busy), .tx(tx)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      we  = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; we = 1'b1; din = 8'hFF;
      tick();
      checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (full !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_over_we cycle %0d: got full=%b busy=%b expected 0/0", i, full, busy); end
      end
      rst = 1'b0; we = 1'b0;
      tick();
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL after_reset: got tx=%b busy=%b expected 1/0", tx, busy); end
   endtask

   task automatic test_idle_line;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         tick();
         checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL idle_tx cycle %0d: got %b expected 1", i, tx); end
         checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy cycle %0d: got %b expected 0", i, busy); end
      end
   endtask

   task automatic test_single_byte;
      logic [9:0] frame;
      frame = 10'b1010101010;
      do_reset();
      we = 1'b1; din = 8'h55;
      tick();
      we = 1'b0;
      checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_write_edge: got tx=%b busy=%b expected 1/1", tx, busy); end
      tick();
      for (int n = 0; n < 10 * CLKS; n++) begin
         checks++; if (tx !== frame[n / CLKS]) begin errors++; $display("[TB] FAIL single_tx cycle %0d: got %b expected %b", n, tx, frame[n / CLKS]); end
         checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy cycle %0d: got %b expected 1", n, busy); end
         tick();
      end
      checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("[TB] FAIL single_end: got busy=%b tx=%b expected 0/1", busy, tx); end
   endtask

   task automatic test_back_to_back;
      logic [9:0] frames [2];
      frames[0] = 10'b1000000010;
      frames[1] = 10'b1100000000;
      do_reset();
      we = 1'b1; din = 8'h01;
      tick();
      din = 8'h80;
      tick();
      we = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int n = 0; n < 10 * CLKS; n++) begin
            checks++; if (tx !== frames[f][n / CLKS]) begin errors++; $display("[TB] FAIL b2b_tx frame %0d cycle %0d: got %b expected %b", f, n, tx, frames[f][n / CLKS]); end
            tick();
         end
         if (f == 0) begin
            checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gap: got tx=%b busy=%b expected 1/1", tx, busy); end
            tick();
         end
      end
      checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("[TB] FAIL b2b_end: got busy=%b tx=%b expected 0/1", busy, tx); end
   endtask

   task automatic test_fifo_full;
      logic [5:0] exp_full;
      logic [5:0] exp_tx;
      logic [9:0] frames [5];
      int         first;
      exp_full = 6'b110000;
      exp_tx   = 6'b000001;
      frames[0] = 10'b1101000000;
      frames[1] = 10'b1101000010;
      frames[2] = 10'b1101000100;
      frames[3] = 10'b1101000110;
      frames[4] = 10'b1101001000;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         we = 1'b1; din = 8'(8'hA0 + i);
         tick();
         checks++; if (full !== exp_full[i]) begin errors++; $display("[TB] FAIL fill_full edge %0d: got %b expected %b", i + 1, full, exp_full[i]); end
         checks++; if (tx !== exp_tx[i]) begin errors++; $display("[TB] FAIL fill_tx edge %0d: got %b expected %b", i + 1, tx, exp_tx[i]); end
      end
      we = 1'b0;
      for (int f = 0; f < 5; f++) begin
         first = (f == 0) ? 4 : 0;
         if (f >= 1) begin
            checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_fall frame %0d: got %b expected 0", f, full); end
         end
         for (int n = first; n < 10 * CLKS; n++) begin
            checks++; if (tx !== frames[f][n / CLKS]) begin errors++; $display("[TB] FAIL fill_tx frame %0d cycle %0d: got %b expected %b", f, n, tx, frames[f][n / CLKS]); end
            tick();
         end
         if (f < 4) begin
            checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL fill_gap frame %0d: got tx=%b busy=%b expected 1/1", f, tx, busy); end
            if (f == 0) begin
               checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_gap_full: got %b expected 1", full); end
            end
            tick();
         end
      end
      checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("[TB] FAIL fill_end: got busy=%b tx=%b expected 0/1", busy, tx); end
   endtask

   task automatic test_full_pop;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         we = 1'b1; din = 8'(8'hB0 + i);
         tick();
      end
      we = 1'b0;
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_filled: got %b expected 1", full); end
      repeat (37) tick();
      checks++; if (tx !== 1'b1 || full !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_gap: got tx=%b full=%b expected 1/1", tx, full); end
      we = 1'b1; din = 8'hEE;
      tick();
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_full: got %b expected 0", full); end
      checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_start: got tx=%b busy=%b expected 0/1", tx, busy); end
      din = 8'h11;
      tick();
      we = 1'b0;
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_refill: got %b expected 1", full); end
      do_reset();
   endtask

   task automatic test_reset_mid_frame;
      do_reset();
      we = 1'b1; din = 8'hF7;
      tick();
      din = 8'h12;
      tick();
      din = 8'h34;
      tick();
      we = 1'b0;
      repeat (15) tick();
      checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_before: got tx=%b busy=%b expected 0/1", tx, busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin errors++; $display("[TB] FAIL midrst_edge: got tx=%b busy=%b full=%b expected 1/0/0", tx, busy, full); end
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_quiet cycle %0d: got tx=%b busy=%b expected 1/0", i, tx, busy); end
      end
   endtask

   // Runs every scenario in order, then reports the totals.
   initial begin
      $display("[TB] start");
      test_reset();
      test_idle_line();
      test_single_byte();
      test_back_to_back();
      test_fifo_full();
      test_full_pop();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
